// File: rtl/alu_result_stage.sv
// Result output stage for the 8-bit ALU units: tags each result with flags and buffers it in a small FIFO.
// Optional even-parity flag per entry is enabled with the ALU_PARITY_FLAG_EN macro.
module alu_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int OPW   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_carry,
    input  logic [OPW-1:0]             in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [OPW-1:0]             out_op,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic                       out_carry,
    output logic                       out_par,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    level_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [OPW-1:0]   mem_op     [DEPTH];
    logic             mem_carry  [DEPTH];
    logic             mem_zero   [DEPTH];
    logic             mem_neg    [DEPTH];

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

    // in_ready depends only on registered pointers, so no out_ready -> in_ready path exists
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full && !flush;
    assign pop       = !empty && out_ready && !flush;
    assign level     = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level_q <= level_q + PW'(1);
            else if (pop && !push) level_q <= level_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_op[i]     <= '0;
                mem_carry[i]  <= 1'b0;
                mem_zero[i]   <= 1'b0;
                mem_neg[i]    <= 1'b0;
            end
        end else if (push) begin
            mem_result[wr_idx] <= in_result;
            mem_op[wr_idx]     <= in_op;
            mem_carry[wr_idx]  <= in_carry;
            mem_zero[wr_idx]   <= (in_result == '0);
            mem_neg[wr_idx]    <= in_result[WIDTH-1];
        end
    end

    // Head fields are forced to 0 whenever the FIFO is empty
    assign out_result = empty ? '0   : mem_result[rd_idx];
    assign out_op     = empty ? '0   : mem_op[rd_idx];
    assign out_carry  = empty ? 1'b0 : mem_carry[rd_idx];
    assign out_zero   = empty ? 1'b0 : mem_zero[rd_idx];
    assign out_neg    = empty ? 1'b0 : mem_neg[rd_idx];

`ifdef ALU_PARITY_FLAG_EN
    logic mem_par [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_par[i] <= 1'b0;
        end else if (push) begin
            mem_par[wr_idx] <= ~^in_result;
        end
    end

    assign out_par = empty ? 1'b0 : mem_par[rd_idx];
`else
    assign out_par = 1'b0;
`endif

endmodule
